mem_io_responder: RTL and testbench

Byte-wide memory and I/O responder on the far end of the CPU's external memory port. It serves the `mem_addr` / `mem_dout` / `mem_wr` / `mem_din` byte interface driven by the CPU's memory controller. It implements 128 KB of RAM, a console input FIFO and output FIFO at 0x30000, and a cycle counter and program-stop register at 0x30004. It is the simulation and FPGA-side counterpart that the CPU core is verified against.

---
 rtl/mem_io_responder.sv | 159 +++++++++++++++
 tb/tb_mem_io_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide responder for the CPU external memory port: 128 KB RAM, console RX/TX
// FIFOs at 0x30000, and a cycle counter / program-stop register at 0x30004.
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop,
    output logic        tx_overflow
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL = (TX_AW + 1)'(TX_DEPTH);

    logic [7:0]       ram_mem [2**RAM_AW];
    logic [7:0]       rx_mem  [RX_DEPTH];
    logic [7:0]       tx_mem  [TX_DEPTH];

    logic [31:0]      cycle_cnt_r, snap_r;
    logic [7:0]       cpu_din_r;
    logic             prog_stop_r, tx_overflow_r, tx_valid_r, rx_ready_r;
    logic [RX_AW-1:0] rx_wp_r, rx_rp_r;
    logic [TX_AW-1:0] tx_wp_r, tx_rp_r;
    logic [RX_AW:0]   rx_cnt_r, rx_cnt_nxt_s;
    logic [TX_AW:0]   tx_cnt_r, tx_cnt_nxt_s;

    logic             wr_req_s, rd_req_s, io_sel_s, ram_sel_s, ram_we_s;
    logic [7:0]       rd_data_s, tx_push_data_s;
    logic             rx_pop_s, rx_push_s, rx_nempty_s, snap_ld_s, stop_set_s;
    logic             tx_push_req_s, tx_push_s, tx_pop_s, tx_full_s, tx_drop_s;
    logic             unused_s;

    assign wr_req_s    = rdy_in & cpu_wr;
    assign rd_req_s    = rdy_in & ~cpu_wr;
    assign io_sel_s    = (cpu_addr[17:16] == 2'b11);
    assign ram_sel_s   = (cpu_addr[17] == 1'b0);
    assign rx_nempty_s = (rx_cnt_r != '0);
    assign rx_push_s   = rx_valid & rx_ready_r;
    assign tx_pop_s    = tx_valid_r & tx_ready;
    assign tx_full_s   = (tx_cnt_r == TX_FULL);
    // A full TX FIFO still accepts a byte when the host pops in the same cycle.
    assign tx_push_s   = tx_push_req_s & (~tx_full_s | tx_pop_s);
    assign tx_drop_s   = tx_push_req_s & tx_full_s & ~tx_pop_s;
    assign unused_s    = ^{cpu_addr[31:18], snap_r[7:0]};

    // Address decode, read-data mux and side-effect strobes for the current request.
    always_comb begin
        rd_data_s      = 8'h00;
        rx_pop_s       = 1'b0;
        snap_ld_s      = 1'b0;
        stop_set_s     = 1'b0;
        tx_push_req_s  = 1'b0;
        tx_push_data_s = 8'h00;
        ram_we_s       = 1'b0;
        if (io_sel_s) begin
            case (cpu_addr[15:0])
                16'h0000: begin
                    if (cpu_wr) begin
                        tx_push_req_s  = wr_req_s & (cpu_dout != 8'h00);
                        tx_push_data_s = cpu_dout;
                    end else begin
                        rx_pop_s  = rd_req_s & rx_nempty_s;
                        rd_data_s = rx_nempty_s ? rx_mem[rx_rp_r] : 8'h00;
                    end
                end
                16'h0004: begin
                    stop_set_s    = wr_req_s;
                    tx_push_req_s = wr_req_s;
                    snap_ld_s     = rd_req_s;
                    rd_data_s     = cycle_cnt_r[7:0];
                end
                16'h0005: rd_data_s = snap_r[15:8];
                16'h0006: rd_data_s = snap_r[23:16];
                16'h0007: rd_data_s = snap_r[31:24];
                default:  rd_data_s = 8'h00;
            endcase
        end else if (ram_sel_s) begin
            ram_we_s  = wr_req_s;
            rd_data_s = ram_mem[cpu_addr[RAM_AW-1:0]];
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Next occupancy of both FIFOs.
    always_comb begin
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_nxt_s = rx_cnt_r + (RX_AW + 1)'(1);
            2'b01:   rx_cnt_nxt_s = rx_cnt_r - (RX_AW + 1)'(1);
            default: rx_cnt_nxt_s = rx_cnt_r;
        endcase
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_nxt_s = tx_cnt_r + (TX_AW + 1)'(1);
            2'b01:   tx_cnt_nxt_s = tx_cnt_r - (TX_AW + 1)'(1);
            default: tx_cnt_nxt_s = tx_cnt_r;
        endcase
    end

    // Storage arrays carry no reset; RAM contents survive rst_in.
    always_ff @(posedge clk_in) begin
        if (ram_we_s) ram_mem[cpu_addr[RAM_AW-1:0]] <= cpu_dout;
        if (rx_push_s) rx_mem[rx_wp_r] <= rx_data;
        if (tx_push_s) tx_mem[tx_wp_r] <= tx_push_data_s;
    end

    // Control state: counter, snapshot, read data, sticky flags and FIFO pointers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt_r   <= 32'h0000_0000;
            snap_r        <= 32'h0000_0000;
            cpu_din_r     <= 8'h00;
            prog_stop_r   <= 1'b0;
            tx_overflow_r <= 1'b0;
            tx_valid_r    <= 1'b0;
            rx_ready_r    <= 1'b1;
            rx_wp_r       <= '0;
            rx_rp_r       <= '0;
            tx_wp_r       <= '0;
            tx_rp_r       <= '0;
            rx_cnt_r      <= '0;
            tx_cnt_r      <= '0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
            if (snap_ld_s)  snap_r      <= cycle_cnt_r;
            if (rd_req_s)   cpu_din_r   <= rd_data_s;
            if (stop_set_s) prog_stop_r <= 1'b1;
            if (tx_drop_s)  tx_overflow_r <= 1'b1;
            if (rx_push_s)  rx_wp_r <= rx_wp_r + RX_AW'(1);
            if (rx_pop_s)   rx_rp_r <= rx_rp_r + RX_AW'(1);
            if (tx_push_s)  tx_wp_r <= tx_wp_r + TX_AW'(1);
            if (tx_pop_s)   tx_rp_r <= tx_rp_r + TX_AW'(1);
            rx_cnt_r   <= rx_cnt_nxt_s;
            tx_cnt_r   <= tx_cnt_nxt_s;
            rx_ready_r <= (rx_cnt_nxt_s != RX_FULL);
            tx_valid_r <= (tx_cnt_nxt_s != '0);
        end
    end

    assign cpu_din     = cpu_din_r;
    assign rx_ready    = rx_ready_r;
    assign tx_valid    = tx_valid_r;
    assign tx_data     = tx_mem[tx_rp_r];
    assign prog_stop   = prog_stop_r;
    assign tx_overflow = tx_overflow_r;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, hole, TX/RX FIFOs, counter snapshot, stop and reset.
module tb_mem_io_responder;
    logic        clk_in, rst_in, rdy_in, cpu_wr;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_dout, cpu_din, rx_data, tx_data;
    logic        rx_valid, rx_ready, tx_valid, tx_ready, prog_stop, tx_overflow;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .prog_stop(prog_stop), .tx_overflow(tx_overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
        rdy_in   = 1'b1;
        cpu_addr = a;
        cpu_wr   = w;
        cpu_dout = d;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; cpu_addr = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        #1 rst_in = 1'b0;
        #2;
        chk("rst_cpu_din", {24'h0, cpu_din}, 32'h00);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        chk("rst_prog_stop", {31'h0, prog_stop}, 32'h0);
        chk("rst_tx_overflow", {31'h0, tx_overflow}, 32'h0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;

        // 511 edges after release: cycle_cnt == 0x1FF at the next request edge
        repeat (511) step();
        bus(32'h0003_0004, 1'b0, 8'h00); step();
        chk("cnt_b0", {24'h0, cpu_din}, 32'hFF);
        bus(32'h0003_0005, 1'b0, 8'h00); step();
        chk("cnt_b1", {24'h0, cpu_din}, 32'h01);
        bus(32'h0003_0006, 1'b0, 8'h00); step();
        chk("cnt_b2", {24'h0, cpu_din}, 32'h00);
        bus(32'h0003_0007, 1'b0, 8'h00); step();
        chk("cnt_b3", {24'h0, cpu_din}, 32'h00);

        // RAM round trip and hole
        bus(32'h0000_0010, 1'b1, 8'hA5); step();
        bus(32'h0000_0010, 1'b0, 8'h00); step();
        chk("ram_rd_10", {24'h0, cpu_din}, 32'hA5);
        bus(32'h0002_0010, 1'b1, 8'h3C); step();
        bus(32'h0002_0010, 1'b0, 8'h00); step();
        chk("hole_rd", {24'h0, cpu_din}, 32'h00);
        bus(32'h0000_0020, 1'b1, 8'h5A); step();
        bus(32'h0000_0020, 1'b0, 8'h00); step();
        chk("ram_rd_20", {24'h0, cpu_din}, 32'h5A);
        bus(32'h0000_0020, 1'b1, 8'h77); rdy_in = 1'b0; step();
        chk("rdy0_hold", {24'h0, cpu_din}, 32'h5A);
        bus(32'h0000_0020, 1'b0, 8'h00); step();
        chk("rdy0_nowrite", {24'h0, cpu_din}, 32'h5A);

        // TX path: 0x00 is not queued
        tx_ready = 1'b1;
        bus(32'h0003_0000, 1'b1, 8'h41); step();
        chk("tx_v_41", {31'h0, tx_valid}, 32'h1);
        chk("tx_d_41", {24'h0, tx_data}, 32'h41);
        bus(32'h0003_0000, 1'b1, 8'h00); step();
        chk("tx_zero_ign", {31'h0, tx_valid}, 32'h0);
        bus(32'h0003_0000, 1'b1, 8'h42); step();
        chk("tx_v_42", {31'h0, tx_valid}, 32'h1);
        chk("tx_d_42", {24'h0, tx_data}, 32'h42);
        bus(32'h0000_0000, 1'b0, 8'h00); step();
        chk("tx_drained", {31'h0, tx_valid}, 32'h0);

        // TX overflow: 17 writes into a 16-deep FIFO with no pops
        tx_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            bus(32'h0003_0000, 1'b1, 8'(i)); step();
            if (i == 16) chk("tx_ovf_16", {31'h0, tx_overflow}, 32'h0);
        end
        chk("tx_ovf_17", {31'h0, tx_overflow}, 32'h1);
        bus(32'h0000_0000, 1'b0, 8'h00);
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("tx_drain_v", {31'h0, tx_valid}, 32'h1);
            chk("tx_drain_d", {24'h0, tx_data}, 32'(i));
            step();
        end
        chk("tx_drain_end", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // RX path
        rx_valid = 1'b1; rx_data = 8'h31; step();
        rx_data = 8'h32; step();
        rx_valid = 1'b0;
        bus(32'h0003_0000, 1'b0, 8'h00); step();
        chk("rx_31", {24'h0, cpu_din}, 32'h31);
        step();
        chk("rx_32", {24'h0, cpu_din}, 32'h32);
        step();
        chk("rx_empty", {24'h0, cpu_din}, 32'h00);
        bus(32'h0000_0000, 1'b0, 8'h00);
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'h50 + 8'(i); step();
            if (i == 14) chk("rx_ready_15", {31'h0, rx_ready}, 32'h1);
        end
        chk("rx_full", {31'h0, rx_ready}, 32'h0);
        rx_data = 8'h99; step();
        rx_valid = 1'b0;
        bus(32'h0003_0000, 1'b0, 8'h00); step();
        chk("rx_head_50", {24'h0, cpu_din}, 32'h50);
        chk("rx_ready_again", {31'h0, rx_ready}, 32'h1);
        bus(32'h0003_0000, 1'b0, 8'h00); step();
        chk("rx_head_51", {24'h0, cpu_din}, 32'h51);

        // Program stop then asynchronous reset mid-stream
        bus(32'h0003_0004, 1'b1, 8'h12); step();
        chk("stop_set", {31'h0, prog_stop}, 32'h1);
        chk("stop_tx_v", {31'h0, tx_valid}, 32'h1);
        chk("stop_tx_d", {24'h0, tx_data}, 32'h00);
        chk("ovf_sticky", {31'h0, tx_overflow}, 32'h1);
        bus(32'h0000_0000, 1'b0, 8'h00);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_stop", {31'h0, prog_stop}, 32'h0);
        chk("arst_tx_v", {31'h0, tx_valid}, 32'h0);
        chk("arst_din", {24'h0, cpu_din}, 32'h00);
        chk("arst_ovf", {31'h0, tx_overflow}, 32'h0);
        chk("arst_rx_rdy", {31'h0, rx_ready}, 32'h1);
        step();
        rst_in = 1'b1;
        bus(32'h0003_0000, 1'b0, 8'h00); step();
        chk("arst_rx_flushed", {24'h0, cpu_din}, 32'h00);
        bus(32'h0000_0010, 1'b0, 8'h00); step();
        chk("ram_kept", {24'h0, cpu_din}, 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
